// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and controls for EX, holds on stall,
// and inserts counted bubbles on branch flush or load-use hazard.
module id_ex_stage_reg #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned IMM_WIDTH = 16,
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned AWIDTH    = 5,
   parameter int unsigned CWIDTH    = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [DWIDTH-1:0]    i_data_rs,
   input  logic [DWIDTH-1:0]    i_data_rt,
   input  logic [IMM_WIDTH-1:0] i_imm,
   input  logic [4:0]           i_funct,
   input  logic                 i_alu_src,
   input  logic [PC_WIDTH-1:0]  i_pc,
   input  logic [AWIDTH-1:0]    i_addr_rs,
   input  logic [AWIDTH-1:0]    i_addr_rt,
   input  logic                 i_uses_rt,
   input  logic [AWIDTH-1:0]    i_addr_rd,
   input  logic                 i_reg_write,
   input  logic                 i_mem_read,
   input  logic                 i_mem_write,
   input  logic                 i_stall,
   input  logic                 i_flush,
   output logic                 o_valid,
   output logic [DWIDTH-1:0]    o_data_rs,
   output logic [DWIDTH-1:0]    o_data_rt,
   output logic [IMM_WIDTH-1:0] o_imm,
   output logic [4:0]           o_funct,
   output logic                 o_alu_src,
   output logic [PC_WIDTH-1:0]  o_pc,
   output logic [AWIDTH-1:0]    o_addr_rd,
   output logic                 o_reg_write,
   output logic                 o_mem_read,
   output logic                 o_mem_write,
   output logic                 o_load_use,
   output logic [CWIDTH-1:0]    o_bubble_cnt
);

   logic load_bubble;
   logic load_instr;
   logic cnt_sat;

   always_comb begin
      o_load_use = o_valid & o_mem_read & (o_addr_rd != '0) & i_valid &
                   ((o_addr_rd == i_addr_rs) | (i_uses_rt & (o_addr_rd == i_addr_rt)));
   end

   // Flush beats stall; stall beats the hazard. An invalid decode slot also becomes a bubble,
   // but only flush and load-use bubbles are counted.
   always_comb begin
      load_bubble = i_flush | (~i_stall & (o_load_use | ~i_valid));
      load_instr  = ~i_flush & ~i_stall & ~o_load_use & i_valid;
      cnt_sat     = &o_bubble_cnt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid     <= 1'b0;
         o_data_rs   <= '0;
         o_data_rt   <= '0;
         o_imm       <= '0;
         o_funct     <= '0;
         o_alu_src   <= 1'b0;
         o_pc        <= '0;
         o_addr_rd   <= '0;
         o_reg_write <= 1'b0;
         o_mem_read  <= 1'b0;
         o_mem_write <= 1'b0;
      end else if (load_bubble) begin
         o_valid     <= 1'b0;
         o_data_rs   <= '0;
         o_data_rt   <= '0;
         o_imm       <= '0;
         o_funct     <= '0;
         o_alu_src   <= 1'b0;
         o_pc        <= '0;
         o_addr_rd   <= '0;
         o_reg_write <= 1'b0;
         o_mem_read  <= 1'b0;
         o_mem_write <= 1'b0;
      end else if (load_instr) begin
         o_valid     <= 1'b1;
         o_data_rs   <= i_data_rs;
         o_data_rt   <= i_data_rt;
         o_imm       <= i_imm;
         o_funct     <= i_funct;
         o_alu_src   <= i_alu_src;
         o_pc        <= i_pc;
         o_addr_rd   <= i_addr_rd;
         o_reg_write <= i_reg_write;
         o_mem_read  <= i_mem_read;
         o_mem_write <= i_mem_write;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_bubble_cnt <= '0;
      end else if ((i_flush | (~i_stall & o_load_use)) && !cnt_sat) begin
         o_bubble_cnt <= o_bubble_cnt + 1'b1;
      end
   end

endmodule
